// File: rtl/dport_mem_responder_pkg.sv
// Shared encodings and payload types for the merlin32i data-port responder.
package dport_mem_responder_pkg;

  localparam int unsigned RV_XLEN = 32;

  // Data-port access size encodings
  localparam logic [1:0] RV_DPORT_SIZE_BYTE = 2'd0;
  localparam logic [1:0] RV_DPORT_SIZE_HALF = 2'd1;
  localparam logic [1:0] RV_DPORT_SIZE_WORD = 2'd2;
  localparam logic [1:0] RV_DPORT_SIZE_ILL  = 2'd3;

  // Hart privilege level encodings
  localparam logic [1:0] RV_HPL_U = 2'd0;
  localparam logic [1:0] RV_HPL_S = 2'd1;
  localparam logic [1:0] RV_HPL_M = 2'd3;

  // Response payload as stored in the response FIFO
  typedef struct packed {
    logic               rerr;
    logic               werr;
    logic [RV_XLEN-1:0] data;
  } dport_rsp_t;

  // Accepted-request bookkeeping carried alongside the synchronous array read
  typedef struct packed {
    logic       valid;
    logic       write;
    logic       err;
    logic [1:0] size;
    logic [1:0] lane;
  } dport_stage1_t;

  // Byte enables for a legal access of the given size at the given byte lane
  function automatic logic [3:0] dport_byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      RV_DPORT_SIZE_BYTE: be = 4'b0001 << lane;
      RV_DPORT_SIZE_HALF: be = 4'b0011 << lane;
      RV_DPORT_SIZE_WORD: be = 4'b1111;
      default:            be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dport_rsp_fifo.sv
// Synchronous response FIFO with a registered head entry and registered count/flags.
module dport_rsp_fifo
  import dport_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_X = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             push,
  input  dport_rsp_t       push_data,
  input  logic             pop,
  output dport_rsp_t       head,
  output logic [DEPTH_X:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_X;
  localparam int unsigned CW    = DEPTH_X + 1;
  localparam int unsigned PW    = DEPTH_X;

  dport_rsp_t    mem_q [DEPTH];
  dport_rsp_t    head_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_next_c;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  // Qualified push/pop and next occupancy; a push into a full FIFO is legal only alongside a pop
  always_comb begin
    do_pop    = pop & ~empty_q;
    do_push   = push & (~full_q | do_pop);
    rd_next_c = rd_ptr_q + PW'(1);
    count_d   = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointers, occupancy, flags and the head register
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else if (clk_en) begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_next_c;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      if (do_pop) begin
        if (count_q > CW'(1))  head_q <= mem_q[rd_next_c];
        else if (do_push)      head_q <= push_data;
      end else if (empty_q && do_push) begin
        head_q <= push_data;
      end
    end
  end

  // Storage array; contents need no reset since occupancy tracks validity
  always_ff @(posedge clk) begin
    if (clk_en && do_push && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = head_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/dport_mem_responder.sv
// Single-port SRAM responder for the merlin32i data port: sized accesses, error flagging, in-order responses.
module dport_mem_responder
  import dport_mem_responder_pkg::*;
#(
  parameter logic [31:0] C_ADDR_BASE   = 32'h0,
  parameter int unsigned C_MEM_DEPTH_X = 10,
  parameter int unsigned C_RSP_DEPTH_X = 2,
  parameter logic [1:0]  C_WR_HPL_MIN  = 2'd0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [1:0]  dreqsize_i,
  input  logic        dreqwrite_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic [31:0] dreqdata_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsprerr_o,
  output logic        drspwerr_o,
  output logic [31:0] drspdata_o
);

  localparam int unsigned MEM_DEPTH = 2 ** C_MEM_DEPTH_X;
  localparam int unsigned IDX_W     = C_MEM_DEPTH_X;
  localparam int unsigned RSP_DEPTH = 2 ** C_RSP_DEPTH_X;
  localparam int unsigned CNT_W     = C_RSP_DEPTH_X + 1;
  localparam int unsigned SUM_W     = C_RSP_DEPTH_X + 2;

  logic [RV_XLEN-1:0] mem_q [MEM_DEPTH];
  logic [RV_XLEN-1:0] rdata_q;
  dport_stage1_t      s1_q;

  logic [31:0]        offset_c;
  logic [IDX_W-1:0]   idx_c;
  logic               in_range_c;
  logic               align_err_c;
  logic               priv_err_c;
  logic               req_err_c;
  logic               accept_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic [31:0]        shifted_c;
  dport_rsp_t         rsp_c;

  dport_rsp_t         fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  // Ready reserves a FIFO slot for whatever sits in stage1, so stage1 can always drain
  always_comb begin
    dreqready_o = ~fifo_full &&
                  ((SUM_W'(s1_q.valid) + SUM_W'(fifo_count)) < SUM_W'(RSP_DEPTH));
  end

  // Request decode: window, alignment, size and write-privilege checks plus lane shifting
  always_comb begin
    accept_c    = clk_en_i & dreqvalid_i & dreqready_o & ~reset_i;
    offset_c    = dreqaddr_i - C_ADDR_BASE;
    idx_c       = offset_c[IDX_W+1:2];
    in_range_c  = ((offset_c >> (IDX_W + 2)) == 32'd0);
    align_err_c = (dreqsize_i == RV_DPORT_SIZE_ILL) ||
                  ((dreqsize_i == RV_DPORT_SIZE_HALF) && dreqaddr_i[0]) ||
                  ((dreqsize_i == RV_DPORT_SIZE_WORD) && (dreqaddr_i[1:0] != 2'b00));
    priv_err_c  = dreqwrite_i && ((3'(dreqhpl_i) + 3'd1) <= 3'(C_WR_HPL_MIN));
    req_err_c   = align_err_c | ~in_range_c | priv_err_c;
    be_c        = dport_byte_en(dreqsize_i, dreqaddr_i[1:0]);
    wdata_c     = dreqdata_i << {dreqaddr_i[1:0], 3'b000};
  end

  // Array access at the acceptance edge: byte-enabled write or synchronous read
  always_ff @(posedge clk_i) begin
    if (accept_c && !req_err_c) begin
      if (dreqwrite_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_c];
      end
    end
  end

  // Stage1 tracks the accepted request whose read data arrives next cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= '0;
    end else if (clk_en_i) begin
      s1_q.valid <= accept_c;
      if (accept_c) begin
        s1_q.write <= dreqwrite_i;
        s1_q.err   <= req_err_c;
        s1_q.size  <= dreqsize_i;
        s1_q.lane  <= dreqaddr_i[1:0];
      end
    end
  end

  // Right-justify and zero-extend load data; errors and stores return zero data
  always_comb begin
    shifted_c = rdata_q >> {s1_q.lane, 3'b000};
    rsp_c     = '0;
    rsp_c.rerr = s1_q.err & ~s1_q.write;
    rsp_c.werr = s1_q.err &  s1_q.write;
    if (!s1_q.err && !s1_q.write) begin
      case (s1_q.size)
        RV_DPORT_SIZE_BYTE: rsp_c.data = 32'(shifted_c[7:0]);
        RV_DPORT_SIZE_HALF: rsp_c.data = 32'(shifted_c[15:0]);
        RV_DPORT_SIZE_WORD: rsp_c.data = shifted_c;
        default:            rsp_c.data = '0;
      endcase
    end
  end

  dport_rsp_fifo #(
    .DEPTH_X (C_RSP_DEPTH_X)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .clk_en    (clk_en_i),
    .push      (s1_q.valid),
    .push_data (rsp_c),
    .pop       (drspready_i),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign drspvalid_o = ~fifo_empty;
  assign drsprerr_o  = fifo_head.rerr;
  assign drspwerr_o  = fifo_head.werr;
  assign drspdata_o  = fifo_head.data;

endmodule
